// File: rtl/top.sv
// Registered-operand ALU: operand/opcode registers with independent load enables,
// a combinational ALU, and registered result/zero/carry outputs (one-edge latency).
module top #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en_A,
    input  logic               i_en_B,
    input  logic               i_en_OP,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_zero,
    output logic               o_overflow
);

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

    logic [NB_DATA-1:0] reg_A;
    logic [NB_DATA-1:0] reg_B;
    logic [NB_OP-1:0]   reg_OP;

    logic [NB_DATA:0]   wide;
    logic [NB_DATA-1:0] res;
    logic               ovf;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            reg_A  <= '0;
            reg_B  <= '0;
            reg_OP <= '0;
        end else begin
            if (i_en_A)  reg_A  <= i_data_a;
            if (i_en_B)  reg_B  <= i_data_b;
            if (i_en_OP) reg_OP <= i_op;
        end
    end

    // Add/sub run one bit wider so the top bit is the carry (add) or borrow (sub).
    always_comb begin
        wide = '0;
        res  = '0;
        ovf  = 1'b0;
        case (reg_OP)
            OP_ADD: begin
                wide = {1'b0, reg_A} + {1'b0, reg_B};
                res  = wide[NB_DATA-1:0];
                ovf  = wide[NB_DATA];
            end
            OP_SUB: begin
                wide = {1'b0, reg_A} - {1'b0, reg_B};
                res  = wide[NB_DATA-1:0];
                ovf  = wide[NB_DATA];
            end
            OP_AND: res = reg_A & reg_B;
            OP_OR:  res = reg_A | reg_B;
            OP_XOR: res = reg_A ^ reg_B;
            OP_NOR: res = ~(reg_A | reg_B);
            OP_SRA: res = {reg_A[NB_DATA-1], reg_A[NB_DATA-1:1]};
            OP_SRL: res = {1'b0, reg_A[NB_DATA-1:1]};
            default: begin
                res = '0;
                ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_result   <= '0;
            o_zero     <= 1'b1;
            o_overflow <= 1'b0;
        end else begin
            o_result   <= res;
            o_zero     <= (res == '0);
            o_overflow <= ovf;
        end
    end

endmodule

// File: tb/tb_top.sv
// Directed and random checks of the registered ALU against a scoreboard of
// {overflow, zero, result} values predicted by an independent reference model.
module tb_top;

    localparam int W  = 8;
    localparam int OW = 6;

    localparam logic [OW-1:0] ADD = 6'b100000;
    localparam logic [OW-1:0] SUB = 6'b100010;
    localparam logic [OW-1:0] AND = 6'b100100;
    localparam logic [OW-1:0] OR  = 6'b100101;
    localparam logic [OW-1:0] XOR = 6'b100110;
    localparam logic [OW-1:0] NOR = 6'b100111;
    localparam logic [OW-1:0] SRA = 6'b000011;
    localparam logic [OW-1:0] SRL = 6'b000010;

    logic          i_clk;
    logic          i_rst;
    logic          i_en_A;
    logic          i_en_B;
    logic          i_en_OP;
    logic [W-1:0]  i_data_a;
    logic [W-1:0]  i_data_b;
    logic [OW-1:0] i_op;
    logic [W-1:0]  o_result;
    logic          o_zero;
    logic          o_overflow;

    logic [W+1:0] exp_q[$];
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic [OW-1:0] m_op;

    int checks = 0;
    int errors = 0;

    top #(.NB_DATA(W), .NB_OP(OW)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_en_A(i_en_A),
        .i_en_B(i_en_B),
        .i_en_OP(i_en_OP),
        .i_data_a(i_data_a),
        .i_data_b(i_data_b),
        .i_op(i_op),
        .o_result(o_result),
        .o_zero(o_zero),
        .o_overflow(o_overflow)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Reference model: returns {ovf, zero, result}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [OW-1:0] op);
        logic [W-1:0] r;
        logic         v;
        r = '0;
        v = 1'b0;
        case (op)
            ADD: begin r = a + b; v = (int'(a) + int'(b)) > 255; end
            SUB: begin r = a - b; v = (a < b); end
            AND: r = a & b;
            OR:  r = a | b;
            XOR: r = a ^ b;
            NOR: r = ~(a | b);
            SRA: r = W'($signed(a) >>> 1);
            SRL: r = a >> 1;
            default: r = '0;
        endcase
        return {v, (r == 0), r};
    endfunction

    function automatic logic [W+1:0] pack(input logic [W-1:0] r, input logic z, input logic v);
        return {v, z, r};
    endfunction

    task automatic check_now(input string tag, input logic [W+1:0] expv);
        logic [W+1:0] got;
        got = {o_overflow, o_zero, o_result};
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s got ovf=%0b zero=%0b res=%0d exp ovf=%0b zero=%0b res=%0d",
                   tag, got[W+1], got[W], got[W-1:0], expv[W+1], expv[W], expv[W-1:0]);
        end
    endtask

    // Driver: called #1 after a rising edge. Loads on the next edge, then the
    // outputs reflect the new registers after the edge after that.
    task automatic step(input string tag, input logic ea, input logic eb, input logic eo,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op);
        i_en_A = ea; i_en_B = eb; i_en_OP = eo;
        i_data_a = a; i_data_b = b; i_op = op;
        @(posedge i_clk); #1;
        if (ea) m_a = a;
        if (eb) m_b = b;
        if (eo) m_op = op;
        i_en_A = 1'b0; i_en_B = 1'b0; i_en_OP = 1'b0;
        exp_q.push_back(model(m_a, m_b, m_op));
        @(posedge i_clk); #1;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            check_now(tag, exp_q.pop_front());
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        m_a = '0; m_b = '0; m_op = '0;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
    endtask

    initial begin
        i_rst = 1'b0;
        i_en_A = 1'b0; i_en_B = 1'b0; i_en_OP = 1'b0;
        i_data_a = '0; i_data_b = '0; i_op = '0;
        m_a = '0; m_b = '0; m_op = '0;
        #2;
        do_reset();
        check_now("reset_state", pack(8'd0, 1'b1, 1'b0));

        // no opcode loaded yet: outputs stay at 0/zero/no-overflow
        step("no_op_after_reset", 1'b1, 1'b1, 1'b0, 8'd7, 8'd3, 6'd0);

        step("add_carry",   1'b1, 1'b1, 1'b1, 8'd200, 8'd100, ADD);
        step("sub_equal",   1'b1, 1'b1, 1'b1, 8'd5,   8'd5,   SUB);
        step("sub_borrow",  1'b1, 1'b1, 1'b1, 8'd3,   8'd5,   SUB);
        step("sra",         1'b1, 1'b1, 1'b1, 8'h81,  8'hFF,  SRA);
        step("srl",         1'b1, 1'b1, 1'b1, 8'h81,  8'h5A,  SRL);
        step("nor_zero",    1'b1, 1'b1, 1'b1, 8'hFF,  8'h00,  NOR);
        step("xor",         1'b1, 1'b1, 1'b1, 8'hF0,  8'h3C,  XOR);
        step("and",         1'b1, 1'b1, 1'b1, 8'hF0,  8'h3C,  AND);
        step("or",          1'b1, 1'b1, 1'b1, 8'hF0,  8'h3C,  OR);
        step("illegal_op",  1'b1, 1'b1, 1'b1, 8'h12,  8'h34,  6'b111111);
        step("add_max",     1'b1, 1'b1, 1'b1, 8'hFF,  8'h01,  ADD);
        step("sub_zero_ff", 1'b1, 1'b1, 1'b1, 8'h00,  8'hFF,  SUB);

        // enable hold: A loaded alone, then data changes with en low
        step("hold_load_a", 1'b1, 1'b0, 1'b0, 8'd10, 8'd0, 6'd0);
        step("hold_add",    1'b0, 1'b1, 1'b1, 8'd99, 8'd1, ADD);
        step("op_only_sub", 1'b0, 1'b0, 1'b1, 8'd0,  8'd0, SUB);
        step("b_only",      1'b0, 1'b1, 1'b0, 8'd0,  8'd20, 6'd0);

        // async reset mid-sequence, with a nonzero result showing beforehand
        step("pre_rst_or", 1'b1, 1'b1, 1'b1, 8'h0F, 8'h30, OR);
        i_en_A = 1'b1; i_data_a = 8'd77;
        @(posedge i_clk); #3;
        i_en_A = 1'b0;
        i_rst = 1'b1;
        #1;
        check_now("async_rst_immediate", pack(8'd0, 1'b1, 1'b0));
        m_a = '0; m_b = '0; m_op = '0;
        i_en_A = 1'b1; i_en_B = 1'b1; i_en_OP = 1'b1;
        i_data_a = 8'd9; i_data_b = 8'd4; i_op = ADD;
        @(posedge i_clk); #1;
        check_now("rst_overrides_en", pack(8'd0, 1'b1, 1'b0));
        i_en_A = 1'b0; i_en_B = 1'b0; i_en_OP = 1'b0;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check_now("post_rst_hold", pack(8'd0, 1'b1, 1'b0));
        step("post_rst_op_only", 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, XOR);
        step("post_rst_nor", 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, NOR);

        // random regression
        for (int i = 0; i < 50; i++) begin
            logic [OW-1:0] op;
            logic [OW-1:0] ops[9];
            ops = '{ADD, SUB, AND, OR, XOR, NOR, SRA, SRL, 6'b010101};
            op = ops[$urandom_range(0, 8)];
            step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                 W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), op);
        end

        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
